// File: rtl/cordic_quad_prerot.sv
// Quadrant pre-rotation for the CORDIC pipeline: wraps a Q3.13 angle into [-pi,pi],
// then folds it into [-pi/2,pi/2], negating (x,y) with saturation when folded.
module cordic_quad_prerot #(
  parameter int W       = 32'sd16,
  parameter int TAG_W   = 32'sd4,
  parameter int PI      = 32'sd25736,
  parameter int HALF_PI = 32'sd12868
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [W-1:0] ang_in,
  input  logic signed [W-1:0] x_in,
  input  logic signed [W-1:0] y_in,
  input  logic [TAG_W-1:0]    tag_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [W-1:0] ang_out,
  output logic signed [W-1:0] x_out,
  output logic signed [W-1:0] y_out,
  output logic [TAG_W-1:0]    tag_out,
  output logic                sat
);

  localparam logic signed [W:0]   PI_E      = (W+1)'(PI);
  localparam logic signed [W:0]   HALF_PI_E = (W+1)'(HALF_PI);
  localparam logic signed [W:0]   TWO_PI_E  = (W+1)'(PI + PI);
  localparam logic signed [W-1:0] MIN_V     = {1'b1, {(W-1){1'b0}}};
  localparam logic signed [W-1:0] MAX_V     = {1'b0, {(W-1){1'b1}}};

  // Returns {saturated, -v}; the most negative value maps to the most positive one.
  function automatic logic [W:0] neg_sat(input logic signed [W-1:0] v);
    logic [W:0] r;
    if (v == MIN_V) begin
      r = {1'b1, MAX_V};
    end else begin
      r = {1'b0, -v};
    end
    return r;
  endfunction

  logic                v1_r;
  logic signed [W-1:0] a1_r;
  logic signed [W-1:0] x1_r;
  logic signed [W-1:0] y1_r;
  logic [TAG_W-1:0]    tag1_r;
  logic                v2_r;

  logic                adv1_s;
  logic                adv2_s;
  logic signed [W:0]   ang_ext_s;
  logic signed [W:0]   wrap_s;
  logic signed [W:0]   a1_ext_s;
  logic signed [W:0]   fold_ang_s;
  logic                fold_s;
  logic [W:0]          negx_s;
  logic [W:0]          negy_s;

  // Pipeline-ready handshake: a stage advances when it is empty or the next one advances.
  always_comb begin
    adv2_s   = !v2_r || out_ready;
    adv1_s   = !v1_r || adv2_s;
    in_ready = adv1_s && reset;
  end

  // Stage-1 wrap of the full +-4.0 input range into [-pi, pi].
  always_comb begin
    ang_ext_s = {ang_in[W-1], ang_in};
    if (ang_ext_s > PI_E) begin
      wrap_s = ang_ext_s - TWO_PI_E;
    end else if (ang_ext_s < -PI_E) begin
      wrap_s = ang_ext_s + TWO_PI_E;
    end else begin
      wrap_s = ang_ext_s;
    end
  end

  // Stage-2 fold into [-pi/2, pi/2]; exactly +-pi/2 stays unfolded.
  always_comb begin
    a1_ext_s = {a1_r[W-1], a1_r};
    negx_s   = neg_sat(x1_r);
    negy_s   = neg_sat(y1_r);
    if (a1_ext_s > HALF_PI_E) begin
      fold_ang_s = a1_ext_s - PI_E;
      fold_s     = 1'b1;
    end else if (a1_ext_s < -HALF_PI_E) begin
      fold_ang_s = a1_ext_s + PI_E;
      fold_s     = 1'b1;
    end else begin
      fold_ang_s = a1_ext_s;
      fold_s     = 1'b0;
    end
  end

  // Stage-1 register: wrapped angle plus untouched operands and tag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v1_r   <= 1'b0;
      a1_r   <= '0;
      x1_r   <= '0;
      y1_r   <= '0;
      tag1_r <= '0;
    end else if (adv1_s) begin
      v1_r <= in_valid;
      if (in_valid) begin
        a1_r   <= wrap_s[W-1:0];
        x1_r   <= x_in;
        y1_r   <= y_in;
        tag1_r <= tag_in;
      end
    end
  end

  // Stage-2 register drives the outputs directly; it holds while stalled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v2_r    <= 1'b0;
      ang_out <= '0;
      x_out   <= '0;
      y_out   <= '0;
      tag_out <= '0;
      sat     <= 1'b0;
    end else if (adv2_s) begin
      v2_r <= v1_r;
      if (v1_r) begin
        ang_out <= fold_ang_s[W-1:0];
        tag_out <= tag1_r;
        if (fold_s) begin
          x_out <= negx_s[W-1:0];
          y_out <= negy_s[W-1:0];
          sat   <= negx_s[W] | negy_s[W];
        end else begin
          x_out <= x1_r;
          y_out <= y1_r;
          sat   <= 1'b0;
        end
      end
    end
  end

  assign out_valid = v2_r;

endmodule
